alu_control_sequencer: RTL and testbench
========================================

// Module: alu_control_sequencer
// PURPOSE
//  Issuing side of the ALU interface: latches one register-register instruction, drives the ALU opcode and
//  the datapath strobes (register-file read/write, Y, Z, HI, LO), then commits the ALU result.
//  Sits between instruction fetch/IR and the datapath; the ALU itself stays purely combinational.
//  Start/done handshake toward the top-level control; one instruction in flight.
// PARAMETERS
//  MULDIV_WAIT  0  extra T4 hold cycles for multiply/divide before z_load (ALU settling); range 0..15
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-high; forces IDLE and all outputs low
//  start        in   1   pulse in IDLE: latch ir and begin; ignored when busy=1
//  ir           in   32  instruction: [31:27] op, [26:23] rd, [22:19] rs1, [18:15] rs2
//  bus_is_zero  in   1   datapath bus == 0 (used only under DIV_ZERO_TRAP_EN)
//  alu_opcode   out  5   opcode to ALU; held stable T3..end of T4
//  rf_rsel      out  4   register-file read select, meaningful when rf_read_en=1
//  rf_read_en   out  1   drive selected register onto bus
//  y_load       out  1   capture bus into Y (ALU Ra operand)
//  z_load       out  1   capture ALU {ZHI,ZLO} into Z
//  zlo_out      out  1   drive Z low word onto bus
//  zhi_out      out  1   drive Z high word onto bus
//  rf_wsel      out  4   register-file write select
//  rf_write_en  out  1   write bus into rf_wsel
//  lo_load      out  1   capture bus into LO
//  hi_load      out  1   capture bus into HI
//  busy         out  1   high from cycle after accepted start until DONE exits
//  done         out  1   one-cycle pulse in DONE
//  illegal      out  1   one-cycle pulse with done when op is not an ALU opcode
//  div_fault    out  1   one-cycle pulse with done on divide by zero (DIV_ZERO_TRAP_EN only, else 0)
// BEHAVIOUR
//  Opcodes: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010,
//   mul 01110, div 01111, neg 10000, not 10001; anything else is illegal.
//  Reset: state IDLE, ir latch 0, every output 0; reset mid-instruction abandons it, no partial write.
//  States: IDLE -> T3 -> T4 -> T5 -> [T6] -> DONE -> IDLE. Illegal op: IDLE -> DONE (illegal=1), no strobes.
//  IDLE: on start latch ir; next T3. Outputs all 0.
//  T3: rf_rsel=rs1, rf_read_en=1, y_load=1 (all legal ops, unary too).
//  T4: binary ops: rf_rsel=rs2, rf_read_en=1; unary (neg/not): rf_read_en=0.
//   mul/div: T4 lasts 1+MULDIV_WAIT cycles, operands/opcode held, z_load only in final cycle.
//   all others: 1 cycle, z_load=1.
//  T5: zlo_out=1; non-mul/div: rf_wsel=rd, rf_write_en=1 -> DONE; mul/div: lo_load=1 -> T6.
//  T6: zhi_out=1, hi_load=1 -> DONE.
//  DONE: done=1 for one cycle -> IDLE; new start accepted the cycle after (back-to-back = 1 idle cycle).
//  Latency start->done: 4 cycles single-word ops; 5+MULDIV_WAIT for mul/div; 1 for illegal.
//  All outputs registered-decode of state (Moore); strobes mutually consistent, never two bus drivers.
//  MULDIV_WAIT counter saturates at parameter value; counter cleared on entering T4.
//  rd=0 written normally (register-file zero policy is not this block's concern).
// CONFIGURATION
//  DIV_ZERO_TRAP_EN defined: div op and bus_is_zero=1 in first T4 cycle -> skip z_load, T5, T6; go to
//   DONE with div_fault=1; HI/LO untouched.
//  Undefined: bus_is_zero ignored, divide proceeds normally; div_fault tied 0.
// STRUCTURE
//  cpu374_pkg: opcode localparams, state enum typedef, op-class helpers (is_unary, is_muldiv, is_legal).
//  One sub-module alu_op_decode: combinational op -> {legal, unary, muldiv} flags; FSM in this file.
// TESTING
//  add, ir op=00011 rd=3 rs1=1 rs2=2, start -> T3 rsel=1 y_load; T4 rsel=2 z_load; T5 wsel=3 write; done @cycle4.
//  neg rd=5 rs1=7 -> T4 rf_read_en=0, z_load=1; rf_write_en wsel=5; done @cycle4.
//  mul, MULDIV_WAIT=3 -> alu_opcode=01110 held 4 T4 cycles, z_load only last; lo_load then hi_load; done @cycle8.
//  op=11111 -> done and illegal same cycle, 1 cycle after start, no strobes ever high.
//  div with bus_is_zero=1 in T4: with DIV_ZERO_TRAP_EN div_fault=1, no lo/hi_load; without -> normal 5-cycle.
//  reset asserted during T4 of mul -> all outputs 0 asynchronously, no write; start pulse during busy ignored.

Source files
------------

// File: rtl/cpu374_pkg.sv
// cpu374_pkg: ALU opcodes, sequencer states and opcode-class helpers
package cpu374_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [2:0] {S_IDLE, S_T3, S_T4, S_T5, S_T6, S_DONE} state_t;

    typedef struct packed {
        logic [4:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

    function automatic logic is_unary(input logic [4:0] op);
        return op == OP_NEG || op == OP_NOT;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                          OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: classifies an opcode into legal / unary / multiply-divide
module alu_op_decode
    import cpu374_pkg::*;
(
    input  logic [4:0] op,
    output logic       legal,
    output logic       unary,
    output logic       muldiv
);

    assign legal  = is_legal(op);
    assign unary  = is_unary(op);
    assign muldiv = is_muldiv(op);

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: issues one register-register ALU instruction through T3..T6 datapath strobes
// Optional DIV_ZERO_TRAP_EN: abort a divide whose divisor bus is zero and report div_fault.
module alu_control_sequencer
    import cpu374_pkg::*;
#(
    parameter int MULDIV_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        bus_is_zero,
    output logic [4:0]  alu_opcode,
    output logic [3:0]  rf_rsel,
    output logic        rf_read_en,
    output logic        y_load,
    output logic        z_load,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic [3:0]  rf_wsel,
    output logic        rf_write_en,
    output logic        lo_load,
    output logic        hi_load,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        div_fault
);

    state_t     state_q, state_d;
    instr_t     ir_q;
    logic [3:0] cnt_q;
    logic       fault_q;
    logic [4:0] op;
    logic       legal, unary, muldiv, t4_last, trap, unused;

    // In IDLE the incoming word is decoded so an illegal op can jump straight to DONE
    assign op = (state_q == S_IDLE) ? ir[31:27] : ir_q.op;

    alu_op_decode u_decode (
        .op     (op),
        .legal  (legal),
        .unary  (unary),
        .muldiv (muldiv)
    );

    assign t4_last = !muldiv || cnt_q == 4'(MULDIV_WAIT);

`ifdef DIV_ZERO_TRAP_EN
    assign trap   = op == OP_DIV && bus_is_zero && cnt_q == 4'd0;
    assign unused = ^ir[14:0];
`else
    assign trap   = 1'b0;
    assign unused = ^{ir[14:0], bus_is_zero};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start)
                ir_q <= instr_t'(ir[31:15]);
            // Zero outside T4, so every T4 entry starts counting from 0
            cnt_q   <= (state_q == S_T4 && !t4_last) ? cnt_q + 4'd1 : 4'd0;
            fault_q <= state_q == S_T4 && trap;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_opcode  = '0;
        rf_rsel     = '0;
        rf_read_en  = 1'b0;
        y_load      = 1'b0;
        z_load      = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        rf_wsel     = '0;
        rf_write_en = 1'b0;
        lo_load     = 1'b0;
        hi_load     = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        div_fault   = 1'b0;
        busy        = state_q != S_IDLE;
        case (state_q)
            S_IDLE: if (start) state_d = legal ? S_T3 : S_DONE;
            S_T3: begin
                alu_opcode = ir_q.op;
                rf_rsel    = ir_q.rs1;
                rf_read_en = 1'b1;
                y_load     = 1'b1;
                state_d    = S_T4;
            end
            S_T4: begin
                alu_opcode = ir_q.op;
                rf_rsel    = unary ? 4'd0 : ir_q.rs2;
                rf_read_en = !unary;
                z_load     = t4_last && !trap;
                state_d    = trap ? S_DONE : t4_last ? S_T5 : S_T4;
            end
            S_T5: begin
                zlo_out     = 1'b1;
                rf_wsel     = muldiv ? 4'd0 : ir_q.rd;
                rf_write_en = !muldiv;
                lo_load     = muldiv;
                state_d     = muldiv ? S_T6 : S_DONE;
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_load = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                illegal   = !legal;
                div_fault = fault_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: per-cycle comparison of the sequencer against an instruction-level model
module tb_alu_control_sequencer;

    localparam int W = 3;

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0, bus_is_zero = 1'b0;
    logic [31:0] ir = '0;
    logic [4:0]  alu_opcode;
    logic [3:0]  rf_rsel, rf_wsel;
    logic        rf_read_en, y_load, z_load, zlo_out, zhi_out, rf_write_en;
    logic        lo_load, hi_load, busy, done, illegal, div_fault;

    alu_control_sequencer #(.MULDIV_WAIT(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .ir          (ir),
        .bus_is_zero (bus_is_zero),
        .alu_opcode  (alu_opcode),
        .rf_rsel     (rf_rsel),
        .rf_read_en  (rf_read_en),
        .y_load      (y_load),
        .z_load      (z_load),
        .zlo_out     (zlo_out),
        .zhi_out     (zhi_out),
        .rf_wsel     (rf_wsel),
        .rf_write_en (rf_write_en),
        .lo_load     (lo_load),
        .hi_load     (hi_load),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .div_fault   (div_fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] opc;
        logic [3:0] rsel;
        logic       ren, yl, zl, zlo, zhi;
        logic [3:0] wsel;
        logic       wen, lol, hil, busy, done, ill, dfault;
    } ov_t;

    ov_t act, ce, cm;
    assign act = {alu_opcode, rf_rsel, rf_read_en, y_load, z_load, zlo_out, zhi_out,
                  rf_wsel, rf_write_en, lo_load, hi_load, busy, done, illegal, div_fault};

    ov_t exp_q[$], msk_q[$];
    int  checks = 0, errors = 0, cyc = 0, done_cyc = -1, strobe_cycles = 0, wr_cycles = 0;
    bit  checking = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done) done_cyc = cyc;
        if (rf_read_en | y_load | z_load | zlo_out | zhi_out | rf_write_en | lo_load | hi_load)
            strobe_cycles++;
        if (rf_write_en | lo_load | hi_load) wr_cycles++;
        if (checking) begin
            if (exp_q.size() > 0) begin
                ce = exp_q.pop_front();
                cm = msk_q.pop_front();
            end else begin
                ce = '0;
                cm = '1;
            end
            checks++;
            if (((act ^ ce) & cm) != '0) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %h expected %h (care %h)", cyc, act, ce, cm);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd, rs1, rs2);
        return {op, rd, rs1, rs2, 15'h2a5a};
    endfunction

    // Don't-care: read select when not reading, write select when not writing, opcode after T4
    task automatic push(input ov_t v, input bit care_opc, input bit strict);
        ov_t m;
        m = '1;
        if (!strict) begin
            if (!v.ren) m.rsel = '0;
            if (!v.wen) m.wsel = '0;
            if (!care_opc) m.opc = '0;
        end
        exp_q.push_back(v);
        msk_q.push_back(m);
    endtask

    task automatic model(input logic [31:0] i, input logic bz);
        logic [4:0] op;
        bit legal, unary, md, trap;
        int n;
        ov_t v;
        op    = i[31:27];
        legal = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                           5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001};
        unary = op == 5'b10000 || op == 5'b10001;
        md    = op == 5'b01110 || op == 5'b01111;
        trap  = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        trap  = op == 5'b01111 && bz;
`else
        if (bz) trap = 1'b0;
`endif
        push('0, 1'b1, 1'b1);
        if (!legal) begin
            v = '0; v.busy = 1; v.done = 1; v.ill = 1;
            push(v, 1'b0, 1'b0);
            return;
        end
        v = '0; v.opc = op; v.rsel = i[22:19]; v.ren = 1; v.yl = 1; v.busy = 1;
        push(v, 1'b1, 1'b0);
        n = trap ? 1 : md ? 1 + W : 1;
        for (int k = 0; k < n; k++) begin
            v = '0; v.opc = op; v.busy = 1; v.ren = !unary;
            v.rsel = unary ? 4'd0 : i[18:15];
            v.zl = (k == n - 1) && !trap;
            push(v, 1'b1, 1'b0);
        end
        if (trap) begin
            v = '0; v.busy = 1; v.done = 1; v.dfault = 1;
            push(v, 1'b0, 1'b0);
            return;
        end
        v = '0; v.busy = 1; v.zlo = 1;
        if (md) v.lol = 1;
        else begin v.wen = 1; v.wsel = i[26:23]; end
        push(v, 1'b0, 1'b0);
        if (md) begin
            v = '0; v.busy = 1; v.zhi = 1; v.hil = 1;
            push(v, 1'b0, 1'b0);
        end
        v = '0; v.busy = 1; v.done = 1;
        push(v, 1'b0, 1'b0);
    endtask

    // Called on a rising edge; returns on the rising edge that leaves DONE
    task automatic run(input logic [31:0] i, input logic bz, input int lat, input int strobes, input bit poke);
        int s_cyc;
        #1;
        ir = i; bus_is_zero = bz; start = 1'b1;
        s_cyc = cyc; done_cyc = -1; strobe_cycles = 0;
        model(i, bz);
        @(posedge clock); #1;
        start = 1'b0; ir = $urandom;
        if (poke) begin
            @(posedge clock); #1;
            start = 1'b1; ir = mk(5'b11111, 4'd1, 4'd1, 4'd1);
            @(posedge clock); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(posedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL timeout op %b: %0d cycles left", i[31:27], exp_q.size());
            exp_q.delete(); msk_q.delete();
        end
        checks++;
        if (done_cyc - s_cyc != lat) begin
            errors++;
            $display("FAIL latency op %b: got %0d expected %0d", i[31:27], done_cyc - s_cyc, lat);
        end
        checks++;
        if (strobe_cycles != strobes) begin
            errors++;
            $display("FAIL strobe_cycles op %b: got %0d expected %0d", i[31:27], strobe_cycles, strobes);
        end
        bus_is_zero = 1'b0;
    endtask

    task automatic reset_mid_mul();
        checking = 1'b0;
        #1;
        ir = mk(5'b01110, 4'd2, 4'd3, 4'd4); start = 1'b1; wr_cycles = 0;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (act != '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", act);
        end
        checks++;
        if (wr_cycles != 0) begin
            errors++;
            $display("FAIL reset_writes: got %0d expected 0", wr_cycles);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        exp_q.delete(); msk_q.delete();
        checking = 1'b1;
    endtask

    logic [4:0] singles[6] = '{5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010};
    logic [4:0] bad[4]     = '{5'b00000, 5'b10010, 5'b01011, 5'b01101};

    initial begin
        #1 reset = 1'b1;
        #2;
        checks++;
        if (act != '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", act);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        checking = 1'b1;
        run(mk(5'b00011, 4'd3, 4'd1, 4'd2), 1'b0, 4, 3, 1'b1);
        run(mk(5'b10000, 4'd5, 4'd7, 4'd0), 1'b0, 4, 3, 1'b0);
        run(mk(5'b01110, 4'd4, 4'd6, 4'd9), 1'b0, 5 + W, 7, 1'b1);
        run(mk(5'b11111, 4'd1, 4'd2, 4'd3), 1'b0, 1, 0, 1'b0);
        run(mk(5'b00100, 4'd15, 4'd14, 4'd13), 1'b0, 4, 3, 1'b0);
        run(mk(5'b10001, 4'd0, 4'd15, 4'd8), 1'b1, 4, 3, 1'b0);
        run(mk(5'b01111, 4'd6, 4'd2, 4'd1), 1'b0, 5 + W, 7, 1'b0);
`ifdef DIV_ZERO_TRAP_EN
        run(mk(5'b01111, 4'd6, 4'd2, 4'd0), 1'b1, 3, 2, 1'b0);
`else
        run(mk(5'b01111, 4'd6, 4'd2, 4'd0), 1'b1, 5 + W, 7, 1'b0);
`endif
        run(mk(5'b01110, 4'd7, 4'd8, 4'd0), 1'b1, 5 + W, 7, 1'b0);
        foreach (singles[k])
            run(mk(singles[k], 4'(k), 4'(k + 1), 4'(k + 2)), 1'b0, 4, 3, 1'b0);
        foreach (bad[k])
            run(mk(bad[k], 4'(k), 4'(k), 4'(k)), 1'b0, 1, 0, 1'b0);
        reset_mid_mul();
        run(mk(5'b00011, 4'd9, 4'd10, 4'd11), 1'b0, 4, 3, 1'b0);
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
